// File: rtl/microop_seq_unit_pkg.sv
// Shared opcodes, FSM encoding and opcode classification for the microop sequencer.
// Logic ops and zero-distance shifts finish in one cycle; other shifts take SHAMT cycles.
package microop_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  function automatic logic is_shift(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/microop_seq_unit_if.sv
// START/BUSY/DONE request bus between a requester and the microop sequencer.
// ZERO/COUT exist only when MICROOP_FLAGS_EN is defined.
interface microop_seq_unit_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [2:0]       OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] F;
`ifdef MICROOP_FLAGS_EN
  logic             ZERO;
  logic             COUT;
`endif

  modport master (
    output START, OP, A, B,
`ifdef MICROOP_FLAGS_EN
    input  ZERO, COUT,
`endif
    input  BUSY, DONE, F
  );

  modport slave (
    input  START, OP, A, B,
`ifdef MICROOP_FLAGS_EN
    output ZERO, COUT,
`endif
    output BUSY, DONE, F
  );

endinterface

// File: rtl/microop_seq_unit_logic.sv
// Combinational WIDTH-bit AND/OR/XOR/NOT-A selector; op_i is the low two opcode bits.
module microop_logic_slice #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] f_o
);

  always_comb begin
    f_o = '0;
    case (op_i)
      2'b00:   f_o = a_i & b_i;
      2'b01:   f_o = a_i | b_i;
      2'b10:   f_o = a_i ^ b_i;
      default: f_o = ~a_i;
    endcase
  end

endmodule

// File: rtl/microop_seq_unit.sv
// Registered logic/shift microop unit: one-cycle logic ops, one-bit-per-clock shifts/rotates.
// Optional ZERO/COUT result flags are enabled with `define MICROOP_FLAGS_EN.
module microop_seq_unit
  import microop_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               CLK,
  input logic               RST,
  microop_seq_unit_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [SW-1:0]    cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] f_q,     f_d;
`ifdef MICROOP_FLAGS_EN
  logic             zero_q,  zero_d;
  logic             cout_q,  cout_d;
`endif

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] logic_f;
  logic [WIDTH-1:0] work_nxt;
  logic             out_bit;

  assign shamt = bus.B[SW-1:0];

  microop_logic_slice #(.WIDTH(WIDTH)) u_logic (
    .op_i (bus.OP[1:0]),
    .a_i  (bus.A),
    .b_i  (bus.B),
    .f_o  (logic_f)
  );

  // out_bit is the bit leaving the word (shifts) or crossing the boundary (rotates).
  always_comb begin
    work_nxt = work_q;
    out_bit  = 1'b0;
    case (op_q)
      OP_SHL: begin
        work_nxt = {work_q[WIDTH-2:0], 1'b0};
        out_bit  = work_q[WIDTH-1];
      end
      OP_SHR: begin
        work_nxt = {1'b0, work_q[WIDTH-1:1]};
        out_bit  = work_q[0];
      end
      OP_ROL: begin
        work_nxt = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        out_bit  = work_q[WIDTH-1];
      end
      default: begin
        work_nxt = {work_q[0], work_q[WIDTH-1:1]};
        out_bit  = work_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    f_d     = f_q;
`ifdef MICROOP_FLAGS_EN
    zero_d  = zero_q;
    cout_d  = cout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          if (is_shift(bus.OP) && (shamt != '0)) begin
            work_d  = bus.A;
            cnt_d   = shamt;
            op_d    = bus.OP;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            f_d    = is_shift(bus.OP) ? bus.A : logic_f;
            done_d = 1'b1;
`ifdef MICROOP_FLAGS_EN
            zero_d = (f_d == '0);
            cout_d = 1'b0;
`endif
          end
        end
      end
      default: begin
        work_d = work_nxt;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          f_d     = work_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`ifdef MICROOP_FLAGS_EN
          zero_d  = (work_nxt == '0);
          cout_d  = out_bit;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      f_q     <= '0;
`ifdef MICROOP_FLAGS_EN
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      f_q     <= f_d;
`ifdef MICROOP_FLAGS_EN
      zero_q  <= zero_d;
      cout_q  <= cout_d;
`endif
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.F    = f_q;
`ifdef MICROOP_FLAGS_EN
  assign bus.ZERO = zero_q;
  assign bus.COUT = cout_q;
`endif

endmodule

// File: tb/tb_microop_seq_unit.sv
// Scoreboard bench for microop_seq_unit (WIDTH=8): stimulus pushes expected results,
// a negedge monitor pops and compares on every DONE.
module tb_microop_seq_unit;
  import microop_pkg::*;

  typedef struct {
    logic [7:0] f;
    logic       z;
    logic       c;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  microop_seq_unit_if #(.WIDTH(8)) bus ();

  microop_seq_unit #(.WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.BUSY === 1'b1 && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic push, input logic [7:0] ef, input logic ec);
    exp_t e;
    wait_idle();
    bus.START = 1'b1;
    bus.OP    = op;
    bus.A     = a;
    bus.B     = b;
    if (push) begin
      e.f = ef;
      e.z = (ef == 8'h00);
      e.c = ec;
      exp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
  endtask

  // Monitor: every DONE must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.DONE === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_F", {24'd0, bus.F}, {24'd0, e.f});
`ifdef MICROOP_FLAGS_EN
          check("flag_ZERO", {31'd0, bus.ZERO}, {31'd0, e.z});
          check("flag_COUT", {31'd0, bus.COUT}, {31'd0, e.c});
`endif
        end
      end
    end
  end

  initial begin
    int cyc;
    int n;
    bus.START = 1'b0;
    bus.OP    = 3'b000;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    RST       = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("reset_BUSY", {31'd0, bus.BUSY}, 32'd0);
    check("reset_DONE", {31'd0, bus.DONE}, 32'd0);
    check("reset_F", {24'd0, bus.F}, 32'd0);
`ifdef MICROOP_FLAGS_EN
    check("reset_ZERO", {31'd0, bus.ZERO}, 32'd0);
    check("reset_COUT", {31'd0, bus.COUT}, 32'd0);
`endif

    // Logic ops, one cycle latency, back-to-back.
    issue(OP_AND, 8'h55, 8'h0F, 1'b1, 8'h05, 1'b0);
    @(negedge CLK);
    check("and_latency_DONE", {31'd0, bus.DONE}, 32'd1);
    check("and_BUSY_low", {31'd0, bus.BUSY}, 32'd0);
    issue(OP_OR,  8'h55, 8'h0F, 1'b1, 8'h5F, 1'b0);
    issue(OP_XOR, 8'h55, 8'h0F, 1'b1, 8'h5A, 1'b0);
    issue(OP_NOT, 8'h55, 8'h0F, 1'b1, 8'hAA, 1'b0);

    // SHL by 3: BUSY for 3 cycles, DONE as BUSY drops.
    issue(OP_SHL, 8'h96, 8'd3, 1'b1, 8'hB0, 1'b0);
    cyc = 0;
    @(negedge CLK);
    while (bus.BUSY === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge CLK);
    end
    check("shl3_busy_cycles", cyc, 32'd3);
    check("shl3_done_timing", {31'd0, bus.DONE}, 32'd1);

    issue(OP_ROR, 8'h96, 8'd1, 1'b1, 8'h4B, 1'b0);
    issue(OP_SHR, 8'h96, 8'd0, 1'b1, 8'h96, 1'b0);
    @(negedge CLK);
    check("shr0_latency_DONE", {31'd0, bus.DONE}, 32'd1);
    check("shr0_BUSY_low", {31'd0, bus.BUSY}, 32'd0);
    issue(OP_SHR, 8'h96, 8'd2, 1'b1, 8'h25, 1'b1);
    issue(OP_ROL, 8'h96, 8'd5, 1'b1, 8'hD2, 1'b0);

    // Abort: SHL by 7, ignored START mid-shift, then RST.
    issue(OP_SHL, 8'hFF, 8'd7, 1'b0, 8'h00, 1'b0);
    @(posedge CLK);
    #1;
    bus.START = 1'b1;
    bus.OP    = OP_AND;
    bus.A     = 8'h33;
    bus.B     = 8'hFF;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    check("ignored_start_BUSY", {31'd0, bus.BUSY}, 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("abort_BUSY", {31'd0, bus.BUSY}, 32'd0);
    check("abort_DONE", {31'd0, bus.DONE}, 32'd0);
    check("abort_F", {24'd0, bus.F}, 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    check("abort_F_held", {24'd0, bus.F}, 32'd0);

    issue(OP_SHL, 8'h80, 8'd1, 1'b1, 8'h00, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    repeat (2) @(posedge CLK);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
